mult_add_arbiter: RTL and testbench

- Shares one pipelined multiply-add datapath (z = a*b + c*d) between N requesters using round-robin arbitration.
- Each requester has a valid/ready request port. Results return on a single response port, tagged with the requester ID.
- Sits between the operand sources and the downstream consumer. It owns both arbitration and pipeline flow control, and applies backpressure from the consumer.

---
 rtl/mult_add_arbiter.sv | 90 +++++++++
 tb/tb_mult_add_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_add_arbiter.sv
// mult_add_arbiter: round-robin shared 3-stage a*b + c*d pipeline with ID-tagged responses.
// The whole pipeline freezes while a response is held by the consumer.
module mult_add_arbiter #(
  parameter int N   = 4,
  parameter int W   = 2,
  parameter int IDW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*W-1:0]     req_a,
  input  logic [N*W-1:0]     req_b,
  input  logic [N*W-1:0]     req_c,
  input  logic [N*W-1:0]     req_d,
  output logic [N-1:0]       req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*W:0]       rsp_z,
  output logic               idle
);
  logic [IDW-1:0] last_q, last_d, gnt_idx, j;
  logic           found, stall, hs;
  logic           s0_v_q, s1_v_q, rsp_v_q;
  logic [W-1:0]   s0_a_q, s0_b_q, s0_c_q, s0_d_q;
  logic [IDW-1:0] s0_id_q, s1_id_q, rsp_id_q;
  logic [2*W-1:0] p1_q, p2_q, p1_d, p2_d;
  logic [2*W:0]   rsp_z_q, z_d;

  assign stall = rsp_v_q & ~rsp_ready;

  // Scan from farthest to nearest so the last hit is the nearest after last_q.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = N; k >= 1; k--) begin
      j = IDW'((int'(last_q) + k) % N);
      if (req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = j;
      end
    end
    req_ready = (found && !stall && !rst) ? (N'(1) << gnt_idx) : '0;
    hs        = |req_ready;
    last_d    = hs ? gnt_idx : last_q;
  end

  assign p1_d = (2*W)'(s0_a_q) * (2*W)'(s0_b_q);
  assign p2_d = (2*W)'(s0_c_q) * (2*W)'(s0_d_q);
  assign z_d  = {1'b0, p1_q} + {1'b0, p2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v_q   <= 1'b0;
      s1_v_q   <= 1'b0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
      rsp_z_q  <= '0;
      last_q   <= IDW'(N - 1);
    end else begin
      last_q <= last_d;
      if (!stall) begin
        s0_v_q   <= hs;
        s1_v_q   <= s0_v_q;
        rsp_v_q  <= s1_v_q;
        rsp_id_q <= s1_id_q;
        rsp_z_q  <= z_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s0_a_q  <= req_a[gnt_idx*W +: W];
      s0_b_q  <= req_b[gnt_idx*W +: W];
      s0_c_q  <= req_c[gnt_idx*W +: W];
      s0_d_q  <= req_d[gnt_idx*W +: W];
      s0_id_q <= gnt_idx;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_id_q <= s0_id_q;
    end
  end

  assign rsp_valid = rsp_v_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign idle      = ~(s0_v_q | s1_v_q | rsp_v_q);
endmodule

// File: tb/tb_mult_add_arbiter.sv
// tb_mult_add_arbiter: directed scenario tests for the shared multiply-add arbiter.
module tb_mult_add_arbiter;
  localparam int N = 4, W = 2, IDW = 2;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic rsp_valid, idle;
  logic [IDW-1:0] rsp_id;
  logic [2*W:0] rsp_z;
  int vec = 0, err = 0;

  mult_add_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_d(req_d), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .idle(idle));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_c[i*W +: W] = W'(c);
    req_d[i*W +: W] = W'(d);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    tick();
    #1;
    vec++; if (req_ready !== 4'b0000) begin err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    vec++; if (rsp_id !== 2'd0) begin err++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    vec++; if (rsp_z !== 5'd0) begin err++; $display("FAIL reset_rsp_z got %0d exp 0", rsp_z); end
    vec++; if (idle !== 1'b1) begin err++; $display("FAIL reset_idle got %b exp 1", idle); end
    tick();
    vec++; if (req_ready !== 4'b0000) begin err++; $display("FAIL reset_ready_hold got %b exp 0000", req_ready); end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single;
    do_reset();
    set_ops(0, 3, 3, 3, 3);
    req_valid = 4'b0001;
    #1;
    vec++; if (req_ready !== 4'b0001) begin err++; $display("FAIL single_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    vec++; if (rsp_valid !== 1'b0 || idle !== 1'b0) begin err++; $display("FAIL single_t1 got v=%b idle=%b exp v=0 idle=0", rsp_valid, idle); end
    tick();
    #1;
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL single_t2 got v=%b exp 0", rsp_valid); end
    tick();
    #1;
    vec++; if (rsp_valid !== 1'b1 || rsp_z !== 5'd18 || rsp_id !== 2'd0) begin err++; $display("FAIL single_rsp got v=%b z=%0d id=%0d exp v=1 z=18 id=0", rsp_valid, rsp_z, rsp_id); end
    tick();
    #1;
    vec++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin err++; $display("FAIL single_drain got v=%b idle=%b exp v=0 idle=1", rsp_valid, idle); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] eg;
    logic ev;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i, 1, 1, 1);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      eg = (c < 5) ? N'(1 << (c % 4)) : '0;
      ev = (c >= 3 && c <= 7);
      vec++; if (req_ready !== eg) begin err++; $display("FAIL b2b_grant c=%0d got %b exp %b", c, req_ready, eg); end
      vec++; if (rsp_valid !== ev) begin err++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
      if (ev) begin
        vec++; if (rsp_id !== IDW'((c - 3) % 4) || rsp_z !== 5'((c - 3) % 4 + 1)) begin err++; $display("FAIL b2b_rsp c=%0d got id=%0d z=%0d exp id=%0d z=%0d", c, rsp_id, rsp_z, (c - 3) % 4, (c - 3) % 4 + 1); end
      end
      tick();
    end
  endtask

  task automatic test_stall;
    logic [N-1:0] pend;
    int got;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i, 1, 1, 1);
    pend = 4'hF;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      req_valid = pend;
      rsp_ready = !(c >= 3 && c <= 7);
      #1;
      if (c >= 3 && c <= 7) begin
        vec++; if (req_ready !== 4'b0000) begin err++; $display("FAIL stall_ready c=%0d got %b exp 0000", c, req_ready); end
        vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 5'd1) begin err++; $display("FAIL stall_hold c=%0d got v=%b id=%0d z=%0d exp v=1 id=0 z=1", c, rsp_valid, rsp_id, rsp_z); end
      end
      if (rsp_valid && rsp_ready) begin
        vec++;
        if (got >= 4) begin err++; $display("FAIL stall_extra got id=%0d z=%0d exp no response", rsp_id, rsp_z); end
        else if (rsp_id !== IDW'(got) || rsp_z !== 5'(got + 1)) begin err++; $display("FAIL stall_order n=%0d got id=%0d z=%0d exp id=%0d z=%0d", got, rsp_id, rsp_z, got, got + 1); end
        got++;
      end
      pend &= ~req_ready;
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    vec++; if (got != 4) begin err++; $display("FAIL stall_count got %0d exp 4", got); end
  endtask

  task automatic test_fairness;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 1, 1, 1, 1);
    req_valid = 4'b0010;
    #1;
    vec++; if (req_ready !== 4'b0010) begin err++; $display("FAIL fair_setup got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b1011;
    #1;
    vec++; if (req_ready !== 4'b1000) begin err++; $display("FAIL fair_g3 got %b exp 1000", req_ready); end
    tick();
    #1;
    vec++; if (req_ready !== 4'b0001) begin err++; $display("FAIL fair_g0 got %b exp 0001", req_ready); end
    tick();
    #1;
    vec++; if (req_ready !== 4'b0010) begin err++; $display("FAIL fair_g1 got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_flight;
    logic ev;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i, 1, 1, 1);
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    #1;
    vec++; if (req_ready !== 4'b0000) begin err++; $display("FAIL flight_rst_ready got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    #1;
    vec++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin err++; $display("FAIL flight_flush got v=%b idle=%b exp v=0 idle=1", rsp_valid, idle); end
    vec++; if (req_ready !== 4'b0001) begin err++; $display("FAIL flight_first_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 5; c < 13; c++) begin
      #1;
      ev = (c == 7);
      vec++; if (rsp_valid !== ev) begin err++; $display("FAIL flight_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
      if (ev) begin
        vec++; if (rsp_id !== 2'd0 || rsp_z !== 5'd1) begin err++; $display("FAIL flight_rsp got id=%0d z=%0d exp id=0 z=1", rsp_id, rsp_z); end
      end
      tick();
    end
  endtask

  task automatic test_boundary;
    logic ev;
    do_reset();
    set_ops(2, 0, 3, 3, 0);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c % 2 == 0 && c <= 6) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        vec++; if (req_ready !== 4'b0100) begin err++; $display("FAIL bnd_grant got %b exp 0100", req_ready); end
      end
      if (c >= 1) begin
        vec++; if (idle !== 1'b0) begin err++; $display("FAIL bnd_idle c=%0d got %b exp 0", c, idle); end
      end
      if (c >= 3) begin
        ev = (c % 2 == 1);
        vec++; if (rsp_valid !== ev) begin err++; $display("FAIL bnd_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
        if (ev) begin
          vec++; if (rsp_z !== 5'd0 || rsp_id !== 2'd2) begin err++; $display("FAIL bnd_rsp c=%0d got z=%0d id=%0d exp z=0 id=2", c, rsp_z, rsp_id); end
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fairness();
    test_reset_flight();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
